// File: rtl/rlbp_pkg.sv
// Shared state encoding and default timing constants for the rlbp frame sequencer.
package rlbp_pkg;

   typedef enum logic [2:0] {
      RLBP_IDLE = 3'd0,
      RLBP_RST  = 3'd1,
      RLBP_INT  = 3'd2,
      RLBP_SEL  = 3'd3,
      RLBP_SH   = 3'd4,
      RLBP_CMP  = 3'd5,
      RLBP_OUT  = 3'd6
   } rlbp_state_e;

   localparam int RLBP_NPIX  = 12;
   localparam int RLBP_T_RST = 4;
   localparam int RLBP_T_SET = 2;
   localparam int RLBP_T_SH  = 4;
   localparam int RLBP_T_CMP = 3;

endpackage

// File: rtl/rlbp_seq_if.sv
// Pattern handoff from the frame sequencer to the digital readout (valid/ready).
interface rlbp_seq_if #(
   parameter int NPIX = 12
);
   logic [NPIX-1:0] pat_o;
   logic            pat_valid_o;
   logic            pat_ready_i;

   modport master (output pat_o, output pat_valid_o, input pat_ready_i);
   modport slave  (input pat_o, input pat_valid_o, output pat_ready_i);
endinterface

// File: rtl/rlbp_sync2.sv
// Two-flop synchronizer for the asynchronous comparator output.
// Latency: 2 cycles. Backpressure: none.
// Reset clears both stages asynchronously.
module rlbp_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);
   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

// File: rtl/rlbp_seq.sv
// Frame sequencer: reset/integrate, then per-pair select/sample/compare, packing one compare bit per pair.
// Latency: T_RST + max(t_int,1) + NPIX*(T_SET+T_SH+T_CMP) cycles to pat_valid_o (+2*NPIX+1 with RLBP_SEQ_SERIAL_EN).
// Backpressure: pattern held in OUT until pat_ready_i; start_i ignored while busy, abort_i always wins.
module rlbp_seq
   import rlbp_pkg::*;
#(
   parameter int NPIX  = RLBP_NPIX,
   parameter int INT_W = 16,
   parameter int T_RST = RLBP_T_RST,
   parameter int T_SET = RLBP_T_SET,
   parameter int T_SH  = RLBP_T_SH,
   parameter int T_CMP = RLBP_T_CMP
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_ni,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic [INT_W-1:0] t_int_i,
   input  logic             cmp_i,
   output logic             sh_rst_o,
   output logic             sw1_o,
   output logic             sw2_o,
   output logic             sh_o,
   output logic             sh_cmp_o,
   output logic [NPIX-1:0]  pd_a_o,
   output logic [NPIX-1:0]  pd_b_o,
   output logic             busy_o,
`ifdef RLBP_SEQ_SERIAL_EN
   output logic             ser_clk_o,
   output logic             ser_data_o,
   output logic             ser_done_o,
`endif
   rlbp_seq_if.master       pat_if
);

   localparam int CNT_W = (INT_W > 8) ? INT_W : 8;
   localparam int K_W   = (NPIX > 1) ? $clog2(NPIX) : 1;
   localparam logic [K_W-1:0] K_LAST = K_W'(NPIX - 1);

   localparam logic [2:0] ST_IDLE = RLBP_IDLE;
   localparam logic [2:0] ST_RST  = RLBP_RST;
   localparam logic [2:0] ST_INT  = RLBP_INT;
   localparam logic [2:0] ST_SEL  = RLBP_SEL;
   localparam logic [2:0] ST_SH   = RLBP_SH;
   localparam logic [2:0] ST_CMP  = RLBP_CMP;
   localparam logic [2:0] ST_OUT  = RLBP_OUT;

   logic [2:0]       state, nxt_state;
   logic [CNT_W-1:0] cnt, nxt_cnt, tint_ld;
   logic [K_W-1:0]   k, nxt_k;
   logic [INT_W-1:0] t_int_q;
   logic [NPIX-1:0]  pat_acc, pat_q, nxt_pat;
   logic             pat_valid_q, valid_nxt, out_nxt, pix_nxt, cmp_s, last_cmp;

   rlbp_sync2 u_sync (
      .clk   (wb_clk_i),
      .rst_n (wb_rst_ni),
      .d     (cmp_i),
      .q     (cmp_s)
   );

   // Down-counter holds (duration - 1); a zero integration time still spends one cycle in INT.
   assign tint_ld  = (t_int_q == '0) ? '0 : CNT_W'(t_int_q - INT_W'(1));
   assign last_cmp = (state == ST_CMP) && (cnt == '0) && !abort_i;
   assign out_nxt  = (nxt_state == ST_OUT);
   assign pix_nxt  = (nxt_state == ST_SEL) || (nxt_state == ST_SH) || (nxt_state == ST_CMP);

   always_comb begin
      nxt_state = state;
      nxt_cnt   = cnt;
      nxt_k     = k;
      nxt_pat   = pat_q;
      if (abort_i) begin
         nxt_state = ST_IDLE;
         nxt_cnt   = '0;
      end else if (state != ST_IDLE && state != ST_OUT && cnt != '0) begin
         nxt_cnt = cnt - CNT_W'(1);
      end else begin
         case (state)
            ST_IDLE: if (start_i) begin
               nxt_state = ST_RST;
               nxt_cnt   = CNT_W'(T_RST - 1);
            end
            ST_RST: begin
               nxt_state = ST_INT;
               nxt_cnt   = tint_ld;
            end
            ST_INT: begin
               nxt_state = ST_SEL;
               nxt_k     = '0;
               nxt_cnt   = CNT_W'(T_SET - 1);
            end
            ST_SEL: begin
               nxt_state = ST_SH;
               nxt_cnt   = CNT_W'(T_SH - 1);
            end
            ST_SH: begin
               nxt_state = ST_CMP;
               nxt_cnt   = CNT_W'(T_CMP - 1);
            end
            ST_CMP: begin
               if (k == K_LAST) begin
                  nxt_state  = ST_OUT;
                  nxt_pat    = pat_acc;
                  nxt_pat[k] = cmp_s;
               end else begin
                  nxt_state = ST_SEL;
                  nxt_k     = k + K_W'(1);
                  nxt_cnt   = CNT_W'(T_SET - 1);
               end
            end
            ST_OUT: if (pat_valid_q && pat_if.pat_ready_i) nxt_state = ST_IDLE;
            default: nxt_state = ST_IDLE;
         endcase
      end
   end

`ifdef RLBP_SEQ_SERIAL_EN
   localparam int SER_W = $clog2(2 * NPIX + 2);
   localparam logic [SER_W-1:0] SER_DONE = SER_W'(2 * NPIX);
   localparam logic [SER_W-1:0] SER_LAST = SER_W'(2 * NPIX + 1);
   localparam logic [NPIX-1:0]  MSB_MASK = NPIX'(1) << (NPIX - 1);

   logic [SER_W-1:0] ser_cnt, nxt_ser;
   logic             ser_msb;

   // Two cycles per bit; the counter parks on SER_LAST, which is the cycle valid rises.
   always_comb begin
      nxt_ser = '0;
      if (state == ST_OUT && out_nxt)
         nxt_ser = (ser_cnt == SER_LAST) ? ser_cnt : ser_cnt + SER_W'(1);
   end

   assign ser_msb   = |((nxt_pat << nxt_ser[SER_W-1:1]) & MSB_MASK);
   assign valid_nxt = out_nxt && (nxt_ser == SER_LAST);

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         ser_cnt    <= '0;
         ser_clk_o  <= 1'b0;
         ser_data_o <= 1'b0;
         ser_done_o <= 1'b0;
      end else begin
         ser_cnt    <= nxt_ser;
         ser_clk_o  <= out_nxt && (nxt_ser < SER_DONE) && nxt_ser[0];
         ser_data_o <= out_nxt && (nxt_ser < SER_DONE) && ser_msb;
         ser_done_o <= out_nxt && (nxt_ser == SER_DONE);
      end
   end
`else
   assign valid_nxt = out_nxt;
`endif

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         k           <= '0;
         t_int_q     <= '0;
         pat_acc     <= '0;
         pat_q       <= '0;
         pat_valid_q <= 1'b0;
         sh_rst_o    <= 1'b0;
         sw1_o       <= 1'b0;
         sw2_o       <= 1'b0;
         sh_o        <= 1'b0;
         sh_cmp_o    <= 1'b0;
         pd_a_o      <= '0;
         pd_b_o      <= '0;
         busy_o      <= 1'b0;
      end else begin
         state <= nxt_state;
         cnt   <= nxt_cnt;
         k     <= nxt_k;
         pat_q <= nxt_pat;
         if (state == ST_IDLE && nxt_state == ST_RST) t_int_q <= t_int_i;
         if (last_cmp) pat_acc[k] <= cmp_s;
         // Strobes decode the next state so every analog control pin is a clean flop output.
         sh_rst_o    <= (nxt_state == ST_RST);
         sw1_o       <= (nxt_state == ST_RST);
         sw2_o       <= (nxt_state == ST_SH);
         sh_o        <= (nxt_state == ST_SH);
         sh_cmp_o    <= (nxt_state == ST_CMP);
         pd_a_o      <= pix_nxt ? (NPIX'(1) << nxt_k) : '0;
         pd_b_o      <= pix_nxt ? (NPIX'(1) << nxt_k) : '0;
         busy_o      <= (nxt_state != ST_IDLE);
         pat_valid_q <= valid_nxt;
      end
   end

   assign pat_if.pat_o       = pat_q;
   assign pat_if.pat_valid_o = pat_valid_q;

endmodule
